// File: rtl/mc_ctrl.sv
`default_nettype none
// ==== mc_ctrl : multi-cycle MIPS control FSM, decodes IR, sequences FETCH..WB, counts retired instrs ====
// ==== Rev 1.0 =================================================================================
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_srcb,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_WB_MEM = 4'd7,
    S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
  } cls_t;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_srcb;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       mem_we;
  } ctrl_t;

  state_t           st;
  cls_t             cls;
  ctrl_t            ctl;
  logic [CNT_W-1:0] cnt;

  cls_t   ncls;
  state_t nxt;
  logic   st_valid;
  logic   br_taken;
  logic   gate;

  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21:   decode = C_ADDU;
               6'h23:   decode = C_SUBU;
               6'h08:   decode = C_JR;
               default: decode = C_NOP;
             endcase
      6'h0D:   decode = C_ORI;
      6'h0F:   decode = C_LUI;
      6'h23:   decode = C_LW;
      6'h2B:   decode = C_SW;
      6'h04:   decode = C_BEQ;
      6'h02:   decode = C_J;
      6'h03:   decode = C_JAL;
      default: decode = C_NOP;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s, input cls_t c);
    case (s)
      S_FETCH:  next_of = S_DECODE;
      S_DECODE: case (c)
                  C_ADDU, C_SUBU:   next_of = S_EXEC_R;
                  C_ORI, C_LUI:     next_of = S_EXEC_I;
                  C_LW, C_SW:       next_of = S_MEM_ADDR;
                  C_BEQ:            next_of = S_BRANCH;
                  C_J, C_JAL, C_JR: next_of = S_JUMP;
                  default:          next_of = S_FETCH;
                endcase
      S_EXEC_R, S_EXEC_I: next_of = S_WB_ALU;
      S_MEM_ADDR: next_of = (c == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next_of = S_WB_MEM;
      default:    next_of = S_FETCH;
    endcase
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input cls_t c);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.ir_we = 1'b1;
        o.pc_we = 1'b1;
      end
      S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
        // WB_ALU keeps the EXEC selects so the ALU result stays stable during write-back
        if (c == C_ORI || c == C_LUI) begin
          o.alu_srcb = 1'b1;
          o.alu_op   = 2'b10;
          o.ext_op   = (c == C_LUI) ? 2'b10 : 2'b00;
        end else begin
          o.alu_op   = (c == C_SUBU) ? 2'b01 : 2'b00;
        end
        if (s == S_WB_ALU) begin
          o.reg_we  = 1'b1;
          o.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
        end
      end
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
        o.alu_srcb = 1'b1;
        o.ext_op   = 2'b01;
        o.mem_we   = (s == S_MEM_WR);
      end
      S_WB_MEM: begin
        o.reg_we = 1'b1;
        o.wd_sel = 2'b01;
      end
      S_BRANCH: o.alu_op = 2'b01;
      S_JUMP: begin
        o.pc_we   = 1'b1;
        o.npc_sel = (c == C_JR) ? 2'b11 : 2'b10;
        if (c == C_JAL) begin
          o.reg_we  = 1'b1;
          o.reg_dst = 2'b10;
          o.wd_sel  = 2'b10;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign ncls     = (st == S_DECODE) ? decode(opcode, funct) : cls;
  assign nxt      = next_of(st, ncls);
  assign st_valid = (st <= S_JUMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_FETCH;
      cls <= C_NOP;
      cnt <= '0;
      ctl <= ctrl_of(S_FETCH, C_NOP);
    end else begin
      st  <= nxt;
      cls <= ncls;
      ctl <= ctrl_of(nxt, ncls);
      if (nxt == S_FETCH && st != S_FETCH && st_valid)
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Branch resolution depends on the live ALU zero flag, so it bypasses the output register
  assign gate     = !reset && st_valid;
  assign br_taken = gate && (st == S_BRANCH) && zero;

  assign pc_we     = (gate && ctl.pc_we) || br_taken;
  assign npc_sel   = br_taken ? 2'b01 : (gate ? ctl.npc_sel : 2'b00);
  assign ir_we     = gate && ctl.ir_we;
  assign reg_we    = gate && ctl.reg_we;
  assign reg_dst   = gate ? ctl.reg_dst  : 2'b00;
  assign wd_sel    = gate ? ctl.wd_sel   : 2'b00;
  assign alu_srcb  = gate && ctl.alu_srcb;
  assign ext_op    = gate ? ctl.ext_op   : 2'b00;
  assign alu_op    = gate ? ctl.alu_op   : 2'b00;
  assign mem_we    = gate && ctl.mem_we;
  assign state     = st;
  assign instr_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ==== tb_mc_ctrl : randomized self-checking bench for mc_ctrl against an instruction-level model ====
// ==== Rev 1.0 ======================================================================================
module tb_mc_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero;
  logic          pc_we, ir_we, reg_we, alu_srcb, mem_we;
  logic [1:0]    npc_sel, reg_dst, wd_sel, ext_op, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_cnt;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_srcb(alu_srcb), .ext_op(ext_op),
    .alu_op(alu_op), .mem_we(mem_we), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: state path, write events and ALU selects per mnemonic
  typedef struct {
    int         lat;
    int         path[5];
    int         rw, mw, xpc;
    logic [1:0] dst, wd, npc, alu, ext;
    logic       srcb;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    e.lat = 2; e.path = '{0, 1, 0, 0, 0};
    e.rw = 0; e.mw = 0; e.xpc = 0;
    e.dst = 0; e.wd = 0; e.npc = 0; e.alu = 0; e.ext = 0; e.srcb = 0;
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      e.lat = 4; e.path[2] = 2; e.path[3] = 4; e.rw = 1; e.dst = 2'b01;
      e.alu = (fn == 6'h23) ? 2'b01 : 2'b00;
    end else if (op == 6'h0D || op == 6'h0F) begin
      e.lat = 4; e.path[2] = 3; e.path[3] = 4; e.rw = 1; e.dst = 2'b00;
      e.srcb = 1; e.alu = 2'b10; e.ext = (op == 6'h0F) ? 2'b10 : 2'b00;
    end else if (op == 6'h23) begin
      e.lat = 5; e.path[2] = 5; e.path[3] = 6; e.path[4] = 7;
      e.rw = 1; e.wd = 2'b01; e.srcb = 1; e.ext = 2'b01;
    end else if (op == 6'h2B) begin
      e.lat = 4; e.path[2] = 5; e.path[3] = 8; e.mw = 1; e.srcb = 1; e.ext = 2'b01;
    end else if (op == 6'h04) begin
      e.lat = 3; e.path[2] = 9; e.alu = 2'b01; e.xpc = int'(z); e.npc = 2'b01;
    end else if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
      e.lat = 3; e.path[2] = 10; e.xpc = 1;
      e.npc = (op == 6'h00) ? 2'b11 : 2'b10;
      if (op == 6'h03) begin
        e.rw = 1; e.dst = 2'b10; e.wd = 2'b10;
      end
    end
    return e;
  endfunction

  // Caller is at a sample point inside FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    int n_pc, n_ir, n_rw, n_mw;
    logic [1:0] g_dst, g_wd, g_npc, g_ext, g_mext, g_alu;
    logic g_srcb;
    e = model(op, fn, z);
    opcode = op; funct = fn; zero = z;
    n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0;
    g_dst = 0; g_wd = 0; g_npc = 0; g_ext = 0; g_mext = 0; g_alu = 0; g_srcb = 0;
    for (int k = 0; k < e.lat; k++) begin
      check($sformatf("state op=%0h k=%0d", op, k), 32'(state), 32'(e.path[k]));
      if (pc_we) begin n_pc++; if (k > 0) g_npc = npc_sel; end
      if (ir_we) n_ir++;
      if (reg_we) begin n_rw++; g_dst = reg_dst; g_wd = wd_sel; end
      if (mem_we) begin n_mw++; g_mext = ext_op; end
      if (k == 2) begin g_srcb = alu_srcb; g_alu = alu_op; g_ext = ext_op; end
      step();
    end
    exp_cnt = exp_cnt + 1'b1;
    check("back_to_fetch", 32'(state), 32'd0);
    check("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
    check("pc_we_pulses", 32'(n_pc), 32'(1 + e.xpc));
    check("ir_we_pulses", 32'(n_ir), 32'd1);
    check("reg_we_pulses", 32'(n_rw), 32'(e.rw));
    check("mem_we_pulses", 32'(n_mw), 32'(e.mw));
    if (e.rw != 0) begin
      check("reg_dst", 32'(g_dst), 32'(e.dst));
      check("wd_sel", 32'(g_wd), 32'(e.wd));
    end
    if (e.mw != 0) check("mem_ext_op", 32'(g_mext), 32'(e.ext));
    if (e.xpc != 0) check("npc_sel", 32'(g_npc), 32'(e.npc));
    if (e.lat > 2) begin
      check("alu_srcb", 32'(g_srcb), 32'(e.srcb));
      check("alu_op", 32'(g_alu), 32'(e.alu));
      check("ext_op", 32'(g_ext), 32'(e.ext));
    end
  endtask

  logic [5:0] legal_op [10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] legal_fn [10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    check("rst_ir_we_forced", 32'(ir_we), 32'd0);
    check("rst_pc_we_forced", 32'(pc_we), 32'd0);
    reset = 1'b0;
    #1;
    check("fetch_ir_we", 32'(ir_we), 32'd1);

    // Reset asserted mid-lw (in MEM_RD) for two cycles
    opcode = 6'h23; funct = 6'h00;
    step(); step(); step();
    check("lw_mem_rd", 32'(state), 32'd6);
    reset = 1'b1;
    #1;
    check("abort_reg_we", 32'(reg_we), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    step();
    check("abort_state", 32'(state), 32'd0);
    check("abort_reg_we2", 32'(reg_we), 32'd0);
    check("abort_ir_we2", 32'(ir_we), 32'd0);
    check("abort_npc2", 32'(npc_sel), 32'd0);
    step();
    reset = 1'b0;
    exp_cnt = '0;
    check("abort_state3", 32'(state), 32'd0);
    check("abort_cnt", 32'(instr_cnt), 32'd0);
    #1;

    // Counter wrap with NOPs (opcode 3F)
    for (int i = 0; i < 15; i++) run_instr(6'h3F, 6'h00, 1'b0);
    check("cnt_15", 32'(instr_cnt), 32'd15);
    run_instr(6'h3F, 6'h00, 1'b0);
    check("cnt_wrap", 32'(instr_cnt), 32'd0);

    // Directed: every supported instruction, both beq outcomes
    for (int i = 0; i < 10; i++) run_instr(legal_op[i], legal_fn[i], 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h00, 6'h3F, 1'b1);

    // Randomized stream, including random (mostly illegal) encodings
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = $urandom_range(0, 12);
      if (sel < 10) run_instr(legal_op[sel], legal_fn[sel], 1'($urandom_range(0, 1)));
      else run_instr(6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
